// File: rtl/ser_word_shifter_pkg.sv
// Shared types and helpers for the parallel-to-serial word shifter.
package ser_word_shifter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    localparam int unsigned GAP_CNT_W = 4;

    // Ceiling log2, never below 1 so a counter always has at least one bit.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((33'd1 << i) < 33'(n)) begin
                r = i + 1;
            end
        end
        return (r == 0) ? 1 : r;
    endfunction

endpackage

// File: rtl/ser_word_shifter_hold_reg.sv
// One-entry holding register with a valid/ready handshake.
// Ready comes from its own flop so it never depends on par_in_valid.
module ser_hold_reg #(
    parameter int unsigned W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] par_in,
    input  logic         par_in_valid,
    input  logic         take,
    output logic [W-1:0] hold_data,
    output logic         hold_full,
    output logic         par_in_ready
);

    // take and accept never coincide: ready is low whenever the entry is full.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hold_data    <= '0;
            hold_full    <= 1'b0;
            par_in_ready <= 1'b1;
        end else if (take) begin
            hold_full    <= 1'b0;
            par_in_ready <= 1'b1;
        end else if (par_in_valid && par_in_ready) begin
            hold_data    <= par_in;
            hold_full    <= 1'b1;
            par_in_ready <= 1'b0;
        end
    end

endmodule

// File: rtl/ser_word_shifter.sv
// Serialises buffered parallel words onto serOut, one bit per clock,
// with selectable bit order and an optional idle gap after each word.
module ser_word_shifter
    import ser_word_shifter_pkg::*;
#(
    parameter int unsigned W          = 8,
    parameter bit          MSB_FIRST  = 1'b1,
    parameter int unsigned GAP        = 0,
    parameter bit          IDLE_LEVEL = 1'b0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic [W-1:0] parIn,
    input  logic         parInValid,
    output logic         parInReady,
    output logic         serOut,
    output logic         serOutEn,
    output logic         wordDone,
    output logic         busy
);

    localparam int unsigned CNT_W = clog2(W);

    state_t               state_q, state_d;
    logic [W-1:0]         shift_q, shift_d;
    logic [CNT_W-1:0]     bit_cnt_q, bit_cnt_d;
    logic [GAP_CNT_W-1:0] gap_cnt_q, gap_cnt_d;
    logic                 take;
    logic [W-1:0]         hold_data;
    logic                 hold_full;
    logic                 head_bit;
    logic [W-1:0]         shift_adv;

    ser_hold_reg #(.W(W)) u_hold (
        .clk          (clk),
        .rst_n        (rst),
        .par_in       (parIn),
        .par_in_valid (parInValid),
        .take         (take),
        .hold_data    (hold_data),
        .hold_full    (hold_full),
        .par_in_ready (parInReady)
    );

    // The head is always the bit on the line; advancing moves the next one into it.
    assign head_bit  = MSB_FIRST ? shift_q[W-1] : shift_q[0];
    assign shift_adv = MSB_FIRST ? {shift_q[W-2:0], 1'b0} : {1'b0, shift_q[W-1:1]};

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q   <= ST_IDLE;
            shift_q   <= '0;
            bit_cnt_q <= '0;
            gap_cnt_q <= '0;
        end else begin
            state_q   <= state_d;
            shift_q   <= shift_d;
            bit_cnt_q <= bit_cnt_d;
            gap_cnt_q <= gap_cnt_d;
        end
    end

    // Next-state logic; take reloads the shifter from the holding register
    always_comb begin
        state_d   = state_q;
        shift_d   = shift_q;
        bit_cnt_d = bit_cnt_q;
        gap_cnt_d = gap_cnt_q;
        take      = 1'b0;

        case (state_q)
            ST_IDLE: begin
                take = hold_full;
            end
            ST_SHIFT: begin
                shift_d = shift_adv;
                if (bit_cnt_q != '0) begin
                    bit_cnt_d = bit_cnt_q - CNT_W'(1);
                end else if (GAP > 0) begin
                    state_d   = ST_GAP;
                    gap_cnt_d = GAP_CNT_W'(GAP - 1);
                end else if (hold_full) begin
                    take = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_GAP: begin
                if (gap_cnt_q != '0) begin
                    gap_cnt_d = gap_cnt_q - GAP_CNT_W'(1);
                end else if (hold_full) begin
                    take = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        if (take) begin
            state_d   = ST_SHIFT;
            shift_d   = hold_data;
            bit_cnt_d = CNT_W'(W - 1);
        end
    end

    // Outputs decoded from registered state only
    always_comb begin
        serOut   = IDLE_LEVEL;
        serOutEn = 1'b0;
        wordDone = 1'b0;
        busy     = (state_q != ST_IDLE) || hold_full;
        if (state_q == ST_SHIFT) begin
            serOut   = head_bit;
            serOutEn = 1'b1;
            wordDone = (bit_cnt_q == '0);
        end
    end

endmodule

// File: tb/tb_ser_word_shifter.sv
// Two shifter instances (MSB-first/no gap/idle 0 and LSB-first/gap 3/idle 1)
// checked every cycle against a queue-based serial line model.
module tb_ser_word_shifter;

    localparam int unsigned W = 8;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic [1:0]   rst_n;
    logic [1:0]   par_valid;
    logic [1:0]   par_ready;
    logic [1:0]   ser_out;
    logic [1:0]   ser_en;
    logic [1:0]   word_done;
    logic [1:0]   busy;
    logic [W-1:0] par_in [2];

    int checks   = 0;
    int failures = 0;

    logic [2:0] log0[$];
    logic [2:0] log1[$];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    for (genvar g = 0; g < 2; g++) begin : gen_dut
        localparam bit          MSB_G  = (g == 0);
        localparam int unsigned GAP_G  = (g == 0) ? 0 : 3;
        localparam bit          IDLE_G = (g == 1);

        ser_word_shifter #(
            .W          (W),
            .MSB_FIRST  (MSB_G),
            .GAP        (GAP_G),
            .IDLE_LEVEL (IDLE_G)
        ) u_dut (
            .clk        (clk),
            .rst        (rst_n[g]),
            .parIn      (par_in[g]),
            .parInValid (par_valid[g]),
            .parInReady (par_ready[g]),
            .serOut     (ser_out[g]),
            .serOutEn   (ser_en[g]),
            .wordDone   (word_done[g]),
            .busy       (busy[g])
        );

        // Model: a one-word buffer feeding a queue of future line symbols {done,en,bit}.
        bit         hold_v = 1'b0;
        logic [W-1:0] hold_d = '0;
        logic [2:0] line[$];

        always @(posedge clk or negedge rst_n[g]) begin
            bit rdy;
            if (!rst_n[g]) begin
                hold_v = 1'b0;
                line.delete();
            end else begin
                rdy = !hold_v;
                if (line.size() > 0) void'(line.pop_front());
                if (line.size() == 0 && hold_v) begin
                    for (int k = 0; k < int'(W); k++) begin
                        logic b;
                        b = MSB_G ? hold_d[int'(W) - 1 - k] : hold_d[k];
                        line.push_back({(k == int'(W) - 1), 1'b1, b});
                    end
                    repeat (GAP_G) line.push_back({2'b00, IDLE_G});
                    hold_v = 1'b0;
                end
                if (rdy && par_valid[g]) begin
                    hold_v = 1'b1;
                    hold_d = par_in[g];
                end
            end
        end

        always @(negedge clk) begin
            logic [2:0] exp_sym;
            exp_sym = (line.size() > 0) ? line[0] : {2'b00, IDLE_G};
            check($sformatf("u%0d.serOut", g),     32'(ser_out[g]),   32'(exp_sym[0]));
            check($sformatf("u%0d.serOutEn", g),   32'(ser_en[g]),    32'(exp_sym[1]));
            check($sformatf("u%0d.wordDone", g),   32'(word_done[g]), 32'(exp_sym[2]));
            check($sformatf("u%0d.parInReady", g), 32'(par_ready[g]), 32'(!hold_v));
            check($sformatf("u%0d.busy", g),       32'(busy[g]),      32'(line.size() > 0 || hold_v));
        end
    end

    always @(negedge clk) begin
        log0.push_back({word_done[0], ser_en[0], ser_out[0]});
        log1.push_back({word_done[1], ser_en[1], ser_out[1]});
    end

    // Summarise a logged stretch of line activity.
    function automatic void analyze(input logic [2:0] q[$], input bit lvl,
                                    output int n_en, output logic [31:0] bits,
                                    output int n_done, output int span,
                                    output int gap8, output bit gap_lvl_ok, output bit done8);
        int first, last, i8, i9;
        first = -1; last = -1; i8 = -1; i9 = -1;
        n_en = 0; bits = '0; n_done = 0; gap_lvl_ok = 1'b1; done8 = 1'b0;
        foreach (q[k]) begin
            if (q[k][2]) n_done++;
            if (q[k][1]) begin
                bits = {bits[30:0], q[k][0]};
                n_en++;
                if (first < 0) first = k;
                last = k;
                if (n_en == 8) begin
                    i8 = k;
                    done8 = q[k][2];
                end
                if (n_en == 9) i9 = k;
            end else if (n_en == 8 && q[k][0] !== lvl) begin
                gap_lvl_ok = 1'b0;
            end
        end
        span = (first < 0) ? 0 : last - first + 1;
        gap8 = (i9 < 0) ? -1 : i9 - i8 - 1;
    endfunction

    task automatic send(input int i, input logic [W-1:0] d);
        int n;
        n = 0;
        @(negedge clk);
        par_valid[i] = 1'b1;
        while (!par_ready[i] && n < 100) begin
            par_in[i] = W'($urandom);
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d.send_wait", i), 32'(n < 100), 32'd1);
        par_in[i] = d;
        @(posedge clk);
    endtask

    task automatic drop_valid(input int i);
        #1;
        par_valid[i] = 1'b0;
        par_in[i]    = W'($urandom);
    endtask

    task automatic wait_idle(input int i);
        int n;
        n = 0;
        @(negedge clk);
        while (busy[i] && n < 300) begin
            @(negedge clk);
            n++;
        end
        check($sformatf("u%0d.idle_wait", i), 32'(n < 300), 32'd1);
        repeat (2) @(negedge clk);
    endtask

    task automatic rand_run(input int i, input int words);
        repeat (words) begin
            send(i, W'($urandom));
            if ($urandom_range(0, 2) != 0) begin
                drop_valid(i);
                repeat ($urandom_range(0, 12)) @(negedge clk);
            end
        end
        drop_valid(i);
        wait_idle(i);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog actual=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n_en, n_done, span, gap8, cnt, n;
        logic [31:0] bits;
        bit gap_ok, done8;

        rst_n     = 2'b00;
        par_valid = 2'b00;
        par_in[0] = '0;
        par_in[1] = '0;
        repeat (3) @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            check($sformatf("rst%0d.ready", i), 32'(par_ready[i]), 32'd1);
            check($sformatf("rst%0d.en", i),    32'(ser_en[i]),    32'd0);
            check($sformatf("rst%0d.out", i),   32'(ser_out[i]),   32'(i == 1));
            check($sformatf("rst%0d.done", i),  32'(word_done[i]), 32'd0);
            check($sformatf("rst%0d.busy", i),  32'(busy[i]),      32'd0);
        end
        rst_n = 2'b11;
        repeat (2) @(negedge clk);

        // Single word, MSB first
        log0.delete();
        send(0, 8'hB4);
        drop_valid(0);
        wait_idle(0);
        analyze(log0, 1'b0, n_en, bits, n_done, span, gap8, gap_ok, done8);
        check("single.n_en",  32'(n_en),   32'd8);
        check("single.bits",  bits,        32'h0000_00B4);
        check("single.span",  32'(span),   32'd8);
        check("single.ndone", 32'(n_done), 32'd1);
        check("single.done8", 32'(done8),  32'd1);
        check("single.busy",  32'(busy[0]), 32'd0);

        // Single word, LSB first
        log1.delete();
        send(1, 8'hB4);
        drop_valid(1);
        wait_idle(1);
        analyze(log1, 1'b1, n_en, bits, n_done, span, gap8, gap_ok, done8);
        check("lsb.n_en", 32'(n_en), 32'd8);
        check("lsb.bits", bits,      32'h0000_002D);

        // Back-to-back with valid held high
        log0.delete();
        send(0, 8'hFF);
        send(0, 8'h00);
        drop_valid(0);
        wait_idle(0);
        analyze(log0, 1'b0, n_en, bits, n_done, span, gap8, gap_ok, done8);
        check("b2b.n_en",  32'(n_en),   32'd16);
        check("b2b.span",  32'(span),   32'd16);
        check("b2b.bits",  bits,        32'h0000_FF00);
        check("b2b.ndone", 32'(n_done), 32'd2);

        // Gap of three idle cycles between words
        log1.delete();
        send(1, 8'hA5);
        send(1, 8'h5A);
        drop_valid(1);
        wait_idle(1);
        analyze(log1, 1'b1, n_en, bits, n_done, span, gap8, gap_ok, done8);
        check("gap.n_en",   32'(n_en),   32'd16);
        check("gap.bits",   bits,        32'h0000_A55A);
        check("gap.len",    32'(gap8),   32'd3);
        check("gap.level",  32'(gap_ok), 32'd1);
        check("gap.ndone",  32'(n_done), 32'd2);

        // Reset during bit 4, then a clean word
        send(0, 8'hB4);
        drop_valid(0);
        cnt = 0;
        n   = 0;
        while (cnt < 4 && n < 100) begin
            @(negedge clk);
            if (ser_en[0]) cnt++;
            n++;
        end
        check("abort.reach_bit4", 32'(cnt), 32'd4);
        #2;
        rst_n[0] = 1'b0;
        #1;
        check("abort.out",   32'(ser_out[0]),   32'd0);
        check("abort.en",    32'(ser_en[0]),    32'd0);
        check("abort.ready", 32'(par_ready[0]), 32'd1);
        check("abort.busy",  32'(busy[0]),      32'd0);
        repeat (2) @(negedge clk);
        rst_n[0] = 1'b1;
        @(negedge clk);
        log0.delete();
        send(0, 8'hC3);
        drop_valid(0);
        wait_idle(0);
        analyze(log0, 1'b0, n_en, bits, n_done, span, gap8, gap_ok, done8);
        check("after.n_en", 32'(n_en), 32'd8);
        check("after.bits", bits,      32'h0000_00C3);

        // Randomised traffic on both instances
        fork
            rand_run(0, 60);
            rand_run(1, 60);
        join

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
